// File: rtl/rc4_encryptor.sv
// RC4 encryptor: fills S (identity), runs the 24-bit-key schedule, then XORs the
// keystream over the plaintext ROM into the ciphertext RAM. One S access per cycle.
module rc4_encryptor #(
  parameter int MSG_LEN   = 32,
  parameter int KEY_BYTES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic [23:0] key,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wdata,
  output logic        s_wren,
  input  logic [7:0]  s_rdata,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rdata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wdata,
  output logic        ct_wren
);

  localparam logic [7:0] LAST_K  = 8'(MSG_LEN - 1);
  localparam logic [7:0] LAST_KB = 8'(KEY_BYTES - 1);

  typedef enum logic [4:0] {
    IDLE, INIT,
    K_RD_I, K_WT_I, K_RD_J, K_WT_J, K_WR_I, K_WR_J,
    P_RD_I, P_WT_I, P_RD_J, P_WT_J, P_WR_I, P_WR_J, P_RD_F, P_WT_F, P_WR_C,
    DONE
  } state_t;

  // Key byte n is taken MSB-first from the latched key.
  function automatic logic [7:0] key_byte(input logic [23:0] k, input logic [7:0] n);
    logic [23:0] sh;
    sh = k << {n, 3'b000};
    return sh[23:16];
  endfunction

  state_t      r_state;
  logic [7:0]  r_i, r_j, r_k, r_kidx, r_si, r_sj;
  logic [23:0] r_key;
  logic        r_ready, r_busy, r_done;
  logic [7:0]  r_s_addr, r_s_wdata, r_pt_addr, r_ct_addr, r_ct_wdata;
  logic        r_s_wren, r_ct_wren;
  logic [7:0]  w_j_ksa, w_j_prga;

  assign w_j_ksa  = r_j + s_rdata + key_byte(r_key, r_kidx);
  assign w_j_prga = r_j + s_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_kidx     <= '0;
      r_si       <= '0;
      r_sj       <= '0;
      r_key      <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_s_wren   <= 1'b0;
      r_pt_addr  <= '0;
      r_ct_addr  <= '0;
      r_ct_wdata <= '0;
      r_ct_wren  <= 1'b0;
    end else if (!pause) begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_key     <= key;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
            r_i       <= '0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_s_wren  <= 1'b1;
            r_state   <= INIT;
          end
        end
        INIT: begin
          if (r_i == 8'hFF) begin
            r_i      <= '0;
            r_j      <= '0;
            r_kidx   <= '0;
            r_s_addr <= '0;
            r_s_wren <= 1'b0;
            r_state  <= K_RD_I;
          end else begin
            r_i       <= r_i + 8'd1;
            r_s_addr  <= r_i + 8'd1;
            r_s_wdata <= r_i + 8'd1;
          end
        end
        // Key schedule: read s[i], read s[j], then write both halves of the swap.
        K_RD_I: r_state <= K_WT_I;
        K_WT_I: begin
          r_si     <= s_rdata;
          r_j      <= w_j_ksa;
          r_s_addr <= w_j_ksa;
          r_state  <= K_RD_J;
        end
        K_RD_J: r_state <= K_WT_J;
        K_WT_J: begin
          r_sj      <= s_rdata;
          r_s_addr  <= r_i;
          r_s_wdata <= s_rdata;
          r_s_wren  <= 1'b1;
          r_state   <= K_WR_I;
        end
        K_WR_I: begin
          r_s_addr  <= r_j;
          r_s_wdata <= r_si;
          r_state   <= K_WR_J;
        end
        K_WR_J: begin
          r_s_wren <= 1'b0;
          r_kidx   <= (r_kidx == LAST_KB) ? 8'd0 : r_kidx + 8'd1;
          if (r_i == 8'hFF) begin
            r_i      <= 8'd1;
            r_j      <= '0;
            r_k      <= '0;
            r_s_addr <= 8'd1;
            r_state  <= P_RD_I;
          end else begin
            r_i      <= r_i + 8'd1;
            r_s_addr <= r_i + 8'd1;
            r_state  <= K_RD_I;
          end
        end
        // Keystream: swap s[i]/s[j], then fetch s[s[i]+s[j]] alongside pt[k].
        P_RD_I: r_state <= P_WT_I;
        P_WT_I: begin
          r_si     <= s_rdata;
          r_j      <= w_j_prga;
          r_s_addr <= w_j_prga;
          r_state  <= P_RD_J;
        end
        P_RD_J: r_state <= P_WT_J;
        P_WT_J: begin
          r_sj      <= s_rdata;
          r_s_addr  <= r_i;
          r_s_wdata <= s_rdata;
          r_s_wren  <= 1'b1;
          r_state   <= P_WR_I;
        end
        P_WR_I: begin
          r_s_addr  <= r_j;
          r_s_wdata <= r_si;
          r_state   <= P_WR_J;
        end
        P_WR_J: begin
          r_s_wren  <= 1'b0;
          r_s_addr  <= r_si + r_sj;
          r_pt_addr <= r_k;
          r_state   <= P_RD_F;
        end
        P_RD_F: r_state <= P_WT_F;
        P_WT_F: begin
          r_ct_addr  <= r_k;
          r_ct_wdata <= s_rdata ^ pt_rdata;
          r_ct_wren  <= 1'b1;
          r_state    <= P_WR_C;
        end
        P_WR_C: begin
          r_ct_wren <= 1'b0;
          if (r_k == LAST_K) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_k      <= r_k + 8'd1;
            r_i      <= r_i + 8'd1;
            r_s_addr <= r_i + 8'd1;
            r_state  <= P_RD_I;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready    = r_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign s_addr   = r_s_addr;
  assign s_wdata  = r_s_wdata;
  assign s_wren   = r_s_wren & ~pause;
  assign pt_addr  = r_pt_addr;
  assign ct_addr  = r_ct_addr;
  assign ct_wdata = r_ct_wdata;
  assign ct_wren  = r_ct_wren & ~pause;

endmodule

// File: tb/tb_rc4_encryptor.sv
// Bench for rc4_encryptor: RAM/ROM models around the DUT, directed RC4 vectors,
// pause / restart / reset-abort scenarios and a textbook RC4 reference.
module tb_rc4_encryptor;

  localparam int MLEN = 9;

  logic        clk = 1'b0;
  logic        reset, start, pause;
  logic [23:0] key;
  logic        ready, busy, done;
  logic [7:0]  s_addr, s_wdata, s_q, pt_addr, pt_q, ct_addr, ct_wdata;
  logic        s_wren, ct_wren;

  logic [7:0]  s_mem  [256];
  logic [7:0]  pt_rom [256];
  logic [7:0]  ct_mem [256];
  logic        ct_clr;

  logic [7:0]  pt1    [MLEN];
  logic [7:0]  ct1    [MLEN];
  logic [7:0]  exp_ct [MLEN];

  int n_checks = 0;
  int n_errors = 0;
  int n_viol   = 0;

  always #5 clk = ~clk;

  rc4_encryptor #(.MSG_LEN(MLEN), .KEY_BYTES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .key(key),
    .ready(ready), .busy(busy), .done(done),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_q),
    .pt_addr(pt_addr), .pt_rdata(pt_q),
    .ct_addr(ct_addr), .ct_wdata(ct_wdata), .ct_wren(ct_wren)
  );

  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wdata;
    s_q  <= s_mem[s_addr];
    pt_q <= pt_rom[pt_addr];
    if (ct_clr) begin
      for (int n = 0; n < 256; n++) ct_mem[n] <= 8'h00;
    end else if (ct_wren) begin
      ct_mem[ct_addr] <= ct_wdata;
    end
  end

  // Write enables must stay low while paused or outside an active run.
  always @(negedge clk) begin
    #2;
    if ((pause || ready || done) && (s_wren || ct_wren)) n_viol++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rc4_model(input logic [23:0] k, input int len);
    logic [7:0] S [256];
    logic [7:0] kb [3];
    logic [7:0] t, i, j;
    kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
    for (int n = 0; n < 256; n++) S[n] = 8'(n);
    j = 8'h00;
    for (int n = 0; n < 256; n++) begin
      j = j + S[n] + kb[n % 3];
      t = S[n]; S[n] = S[j]; S[j] = t;
    end
    i = 8'h00; j = 8'h00;
    for (int n = 0; n < len; n++) begin
      i = i + 8'd1;
      j = j + S[i];
      t = S[i]; S[i] = S[j]; S[j] = t;
      t = S[i] + S[j];
      exp_ct[n] = S[t] ^ pt_rom[n];
    end
  endtask

  task automatic clear_ct();
    ct_clr = 1'b1;
    @(negedge clk);
    ct_clr = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: plain + INIT probe, 1: periodic pause, 2: start re-pulsed mid-KSA
  task automatic run_enc(input logic [23:0] k, input int mode);
    bit ok, probed, saw;
    int bad;
    key = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0; probed = 0; saw = 0;
    for (int c = 0; c < 20000 && !ok; c++) begin
      if (mode == 1) pause = ((c % 50) >= 47);
      if (mode == 2) start = (c == 800);
      @(negedge clk);
      if (mode == 0 && !probed) begin
        if (s_wren) saw = 1;
        else if (saw) begin
          bad = 0;
          for (int n = 0; n < 256; n++) if (s_mem[n] !== 8'(n)) bad++;
          check_val("init_identity", 32'(bad), 32'd0);
          probed = 1;
        end
      end
      if (done) ok = 1;
    end
    pause = 1'b0;
    start = 1'b0;
    check_val("done_reached", 32'(ok), 32'd1);
    if (mode == 0) check_val("init_probed", 32'(probed), 32'd1);
  endtask

  task automatic check_ct(input string tag);
    for (int n = 0; n < MLEN; n++)
      check_val($sformatf("%s_ct%0d", tag, n), 32'(ct_mem[n]), 32'(exp_ct[n]));
    check_val($sformatf("%s_ct_past_end", tag), 32'(ct_mem[MLEN]), 32'd0);
  endtask

  initial begin
    int bad;
    int cnt [256];
    reset = 1'b1; start = 1'b0; pause = 1'b0; key = '0; ct_clr = 1'b0;
    pt1 = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    ct1 = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int n = 0; n < 256; n++) pt_rom[n] = 8'h00;
    repeat (3) @(negedge clk);

    check_val("rst_ready", 32'(ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_s_wren", 32'(s_wren), 32'd0);
    check_val("rst_ct_wren", 32'(ct_wren), 32'd0);
    check_val("rst_s_addr", 32'(s_addr), 32'd0);
    check_val("rst_ct_addr", 32'(ct_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Case 1: "Key" / "Plaintext"
    for (int n = 0; n < MLEN; n++) pt_rom[n] = pt1[n];
    for (int n = 0; n < MLEN; n++) exp_ct[n] = ct1[n];
    clear_ct();
    run_enc(24'h4B6579, 0);
    check_val("c1_done", 32'(done), 32'd1);
    check_val("c1_busy", 32'(busy), 32'd0);
    check_val("c1_ready", 32'(ready), 32'd0);
    check_ct("c1");
    for (int n = 0; n < 256; n++) cnt[n] = 0;
    for (int n = 0; n < 256; n++) cnt[s_mem[n]]++;
    bad = 0;
    for (int n = 0; n < 256; n++) if (cnt[n] != 1) bad++;
    check_val("s_permutation", 32'(bad), 32'd0);

    // Round trip: ciphertext back in as plaintext
    repeat (4) @(negedge clk);
    check_val("done_held", 32'(done), 32'd1);
    for (int n = 0; n < MLEN; n++) pt_rom[n] = ct1[n];
    for (int n = 0; n < MLEN; n++) exp_ct[n] = pt1[n];
    clear_ct();
    run_enc(24'h4B6579, 0);
    check_ct("rt");

    // Pause every 50 cycles must not change results
    for (int n = 0; n < MLEN; n++) pt_rom[n] = pt1[n];
    for (int n = 0; n < MLEN; n++) exp_ct[n] = ct1[n];
    clear_ct();
    run_enc(24'h4B6579, 1);
    check_ct("pause");

    // start re-pulsed mid-KSA is ignored
    clear_ct();
    run_enc(24'h4B6579, 2);
    check_ct("restart");

    // Reset in the middle of the keystream phase
    clear_ct();
    key = 24'h4B6579;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1820) @(negedge clk);
    check_val("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_val("abort_ready", 32'(ready), 32'd1);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_s_wren", 32'(s_wren), 32'd0);
    check_val("abort_ct_wren", 32'(ct_wren), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    clear_ct();
    run_enc(24'h4B6579, 0);
    check_ct("after_abort");

    // Zero key, zero plaintext: ciphertext is the raw keystream
    for (int n = 0; n < MLEN; n++) pt_rom[n] = 8'h00;
    rc4_model(24'h000000, MLEN);
    clear_ct();
    run_enc(24'h000000, 0);
    check_ct("zkey");

    repeat (5) @(negedge clk);
    check_val("zkey_done_held", 32'(done), 32'd1);
    pause = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
    @(negedge clk);
    check_val("paused_start_done", 32'(done), 32'd1);
    check_val("paused_start_busy", 32'(busy), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("restart_done_clr", 32'(done), 32'd0);
    check_val("restart_busy", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);

    check_val("wren_guard", 32'(n_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
